xcorr_peak_search: RTL

//  Peak-lag detector for the microphone-pair cross-correlation path, on the clk_60MHz domain.

---
 rtl/xcorr_peak_search_pkg.sv | 16 +
 rtl/xcorr_peak_search_abs_sat.sv | 23 ++
 rtl/xcorr_peak_search.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/xcorr_peak_search_pkg.sv
// Shared definitions for the microphone-pair cross-correlation peak search.
// Holds the frame FSM state type and default widths for the mic path.
package xcorr_peak_search_pkg;

    localparam int MIC_LAGNUM  = 10;
    localparam int MIC_DATA_W  = 32;
    localparam int MIC_LAG_W   = 6;
    localparam int MIC_TIMEOUT = 4096;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/xcorr_peak_search_abs_sat.sv
// Combinational saturating magnitude: |x| that never wraps.
// The most-negative input clamps to the largest positive value.
module xcorr_abs_sat #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_x,
    output logic [DATA_W-1:0] o_mag
);

    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

    always_comb begin
        if (i_x == MOST_NEG) begin
            o_mag = MOST_POS;
        end else if (i_x[DATA_W-1]) begin
            o_mag = -i_x;
        end else begin
            o_mag = i_x;
        end
    end

endmodule

// File: rtl/xcorr_peak_search.sv
// Peak-lag detector for one cross-correlation frame (lag -LAGNUM..+LAGNUM).
// Tracks max |xcorr| with a frame FSM, abort/timeout and overrun detection.
module xcorr_peak_search
    import xcorr_peak_search_pkg::*;
#(
    parameter int LAGNUM  = MIC_LAGNUM,
    parameter int DATA_W  = MIC_DATA_W,
    parameter int LAG_W   = MIC_LAG_W,
    parameter int TIMEOUT = MIC_TIMEOUT
) (
    input  logic                    clk_60MHz,
    input  logic                    rst_n,
    input  logic                    frame_start,
    input  logic                    xc_valid,
    input  logic [DATA_W-1:0]       xc_data,
    input  logic [DATA_W-1:0]       thresh,
    output logic                    busy,
    output logic                    peak_valid,
    output logic signed [LAG_W-1:0] peak_lag,
    output logic [DATA_W-1:0]       peak_mag,
    output logic                    peak_conf,
    output logic                    err_short,
    output logic                    err_overrun
);

    localparam int FRAME_LEN = 2 * LAGNUM + 1;
    localparam int IDX_W     = $clog2(FRAME_LEN + 1);
    localparam int TMR_W     = $clog2(TIMEOUT + 2);
    localparam logic signed [LAG_W-1:0] LAG_MIN = LAG_W'(-LAGNUM);

    if (LAGNUM > (1 << (LAG_W - 1)) - 1) begin : g_bad_lag_w
        $error("LAG_W too narrow for LAGNUM");
    end

    state_t                    r_state, w_state_nxt;
    logic signed [LAG_W-1:0]   r_lag, w_lag_nxt;
    logic [IDX_W-1:0]          r_idx, w_idx_nxt;
    logic [TMR_W-1:0]          r_timer, w_timer_nxt;
    logic [DATA_W-1:0]         r_run_max, w_run_max_nxt;
    logic signed [LAG_W-1:0]   r_run_lag, w_run_lag_nxt;
    logic                      r_peak_valid;
    logic signed [LAG_W-1:0]   r_peak_lag;
    logic [DATA_W-1:0]         r_peak_mag;
    logic                      r_peak_conf;
    logic                      r_err_short;
    logic                      r_err_ovr;

    logic [DATA_W-1:0]         w_mag;
    logic                      w_in_accum;
    logic                      w_accept;
    logic                      w_last;
    logic                      w_tmo;
    logic signed [LAG_W-1:0]   w_base_lag;
    logic [IDX_W-1:0]          w_base_idx;
    logic [DATA_W-1:0]         w_base_max;
    logic signed [LAG_W-1:0]   w_base_rlag;
    logic [DATA_W-1:0]         w_new_max;
    logic signed [LAG_W-1:0]   w_new_rlag;

    xcorr_abs_sat #(.DATA_W(DATA_W)) u_abs (
        .i_x   (xc_data),
        .o_mag (w_mag)
    );

    // frame_start restarts the frame; a coincident sample is its first.
    always_comb begin
        w_in_accum  = (r_state == ST_ACCUM);
        w_accept    = xc_valid && (w_in_accum || frame_start);
        w_base_lag  = frame_start ? LAG_MIN : r_lag;
        w_base_idx  = frame_start ? '0 : r_idx;
        w_base_max  = frame_start ? '0 : r_run_max;
        w_base_rlag = frame_start ? LAG_MIN : r_run_lag;
        w_new_max   = w_base_max;
        w_new_rlag  = w_base_rlag;
        if (w_accept && (w_mag >= w_base_max)) begin
            w_new_max  = w_mag;
            w_new_rlag = w_base_lag;
        end
        w_last = w_accept && (w_base_idx == IDX_W'(FRAME_LEN - 1));
        w_tmo  = (TIMEOUT != 0) && w_in_accum && !frame_start
                 && !w_accept && (r_timer == TMR_W'(TIMEOUT - 1));
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_lag_nxt     = r_lag;
        w_idx_nxt     = r_idx;
        w_timer_nxt   = r_timer;
        w_run_max_nxt = r_run_max;
        w_run_lag_nxt = r_run_lag;
        unique case (r_state)
            ST_IDLE:   if (frame_start) w_state_nxt = ST_ACCUM;
            ST_ACCUM:  if (w_tmo) w_state_nxt = ST_IDLE;
            ST_REPORT: w_state_nxt = frame_start ? ST_ACCUM : ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
        if (w_last) begin
            w_state_nxt = ST_REPORT;
        end
        if (frame_start || w_in_accum) begin
            w_lag_nxt     = w_accept ? w_base_lag + LAG_W'(1) : w_base_lag;
            w_idx_nxt     = w_accept ? w_base_idx + IDX_W'(1) : w_base_idx;
            w_run_max_nxt = w_new_max;
            w_run_lag_nxt = w_new_rlag;
            w_timer_nxt   = (w_accept || frame_start) ? '0
                                                      : r_timer + TMR_W'(1);
        end
    end

    always_ff @(posedge clk_60MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_lag     <= LAG_MIN;
            r_idx     <= '0;
            r_timer   <= '0;
            r_run_max <= '0;
            r_run_lag <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lag     <= w_lag_nxt;
            r_idx     <= w_idx_nxt;
            r_timer   <= w_timer_nxt;
            r_run_max <= w_run_max_nxt;
            r_run_lag <= w_run_lag_nxt;
        end
    end

    always_ff @(posedge clk_60MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_peak_valid <= 1'b0;
            r_peak_lag   <= '0;
            r_peak_mag   <= '0;
            r_peak_conf  <= 1'b0;
            r_err_short  <= 1'b0;
            r_err_ovr    <= 1'b0;
        end else begin
            r_peak_valid <= w_last;
            r_err_short  <= (w_in_accum && frame_start) || w_tmo;
            r_err_ovr    <= xc_valid && !frame_start && !w_in_accum;
            if (w_last) begin
                r_peak_lag  <= w_new_rlag;
                r_peak_mag  <= w_new_max;
                r_peak_conf <= (w_new_max >= thresh);
            end
        end
    end

    assign busy        = w_in_accum;
    assign peak_valid  = r_peak_valid;
    assign peak_lag    = r_peak_lag;
    assign peak_mag    = r_peak_mag;
    assign peak_conf   = r_peak_conf;
    assign err_short   = r_err_short;
    assign err_overrun = r_err_ovr;

endmodule
